// File: rtl/ov7670_pkg.sv
// Shared types and helpers for the OV7670 camera emulator.
// Holds the timing-state and pattern enums, the colour-bar palette and the RGB444 byte packer.
package ov7670_pkg;

    typedef enum logic [2:0] {
        IDLE,
        VSYNC,
        VBACK,
        ACTIVE,
        VFRONT
    } state_t;

    typedef enum logic [1:0] {
        PAT_BARS,
        PAT_ZEBRA,
        PAT_SOLID,
        PAT_RAMP
    } pattern_t;

    localparam logic [11:0] BAR_COLOURS [8] = '{
        12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
        12'hF0F, 12'hF00, 12'h00F, 12'h000
    };

    // Even bytes carry red in the low nibble, odd bytes carry green and blue.
    function automatic logic [7:0] packByte(input logic [11:0] rgb, input logic phase);
        return phase ? rgb[7:0] : {4'h0, rgb[11:8]};
    endfunction

endpackage

// File: rtl/ov7670_pattern_gen.sv
// Combinational test-pattern source: maps a pixel coordinate and the latched
// frame settings to a 12-bit RGB444 colour.
module ov7670_pattern_gen
    import ov7670_pkg::*;
#(
    parameter int IMG_WIDTH = 320,
    parameter int STRIPE_H  = 16,
    parameter int X_W       = 9,
    parameter int Y_W       = 8
) (
    input  logic [X_W-1:0] i_x,
    input  logic [Y_W-1:0] i_y,
    input  logic [3:0]     i_frameCnt,
    input  pattern_t       i_pattern,
    input  logic [11:0]    i_solid,
    output logic [11:0]    o_rgb
);

    localparam int BAR_W        = IMG_WIDTH / 8;
    localparam int STRIPE_SHIFT = $clog2(STRIPE_H);

    always_comb begin
        o_rgb = 12'h000;
        unique case (i_pattern)
            PAT_BARS:  o_rgb = BAR_COLOURS[3'(int'(i_x) / BAR_W)];
            PAT_ZEBRA: o_rgb = (((int'(i_y) >> STRIPE_SHIFT) & 1) == 0) ? 12'hFFF : 12'h000;
            PAT_SOLID: o_rgb = i_solid;
            PAT_RAMP:  o_rgb = {4'(i_x), 4'(i_y), i_frameCnt};
            default:   o_rgb = 12'h000;
        endcase
    end

endmodule

// File: rtl/ov7670_stream_gen.sv
// OV7670 camera emulator: drives VSYNC/HREF/DATA in RGB444 two-byte format with
// programmable frame timing; every output is registered from the next-state values.
module ov7670_stream_gen
    import ov7670_pkg::*;
#(
    parameter int IMG_WIDTH   = 320,
    parameter int IMG_HEIGHT  = 240,
    parameter int H_BLANK     = 144,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10,
    parameter int STRIPE_H    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [11:0] solid_rgb,
    output logic        vsync,
    output logic        href,
    output logic [7:0]  data,
    output logic        frame_start,
    output logic        frame_done,
    output logic        busy
);

    localparam int LINE_CLKS   = 2 * IMG_WIDTH + H_BLANK;
    localparam int ACTIVE_CLKS = 2 * IMG_WIDTH;
    localparam int MAX_A       = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
    localparam int MAX_B       = (IMG_HEIGHT > V_FRONT) ? IMG_HEIGHT : V_FRONT;
    localparam int MAX_LINES   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int COL_W       = (LINE_CLKS > 1) ? $clog2(LINE_CLKS) : 1;
    localparam int LINE_W      = (MAX_LINES > 1) ? $clog2(MAX_LINES) : 1;
    localparam int X_W         = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

    state_t             r_state;
    logic [COL_W-1:0]   r_col;
    logic [LINE_W-1:0]  r_line;
    pattern_t           r_pattern;
    logic [11:0]        r_solid;
    logic [3:0]         r_frameCnt;
    logic               r_vsync, r_href, r_frameStart, r_frameDone, r_busy;
    logic [7:0]         r_data;

    state_t             w_nextState;
    logic [COL_W-1:0]   w_nextCol;
    logic [LINE_W-1:0]  w_nextLine;
    logic               w_colLast, w_lineLast, w_enterVsync;
    logic               w_vsync, w_href, w_frameDone, w_busy;
    logic [7:0]         w_data;
    logic [11:0]        w_rgb;

    ov7670_pattern_gen #(
        .IMG_WIDTH (IMG_WIDTH),
        .STRIPE_H  (STRIPE_H),
        .X_W       (X_W),
        .Y_W       (LINE_W)
    ) u_patternGen (
        .i_x        (X_W'(w_nextCol >> 1)),
        .i_y        (w_nextLine),
        .i_frameCnt (r_frameCnt),
        .i_pattern  (r_pattern),
        .i_solid    (r_solid),
        .o_rgb      (w_rgb)
    );

    // Column wraps every line; the line counter restarts in each new state.
    always_comb begin
        w_nextState = r_state;
        w_nextCol   = '0;
        w_nextLine  = '0;
        w_colLast   = (r_col == COL_W'(LINE_CLKS - 1));
        w_lineLast  = 1'b0;
        unique case (r_state)
            VSYNC:   w_lineLast = (r_line == LINE_W'(VSYNC_LINES - 1));
            VBACK:   w_lineLast = (r_line == LINE_W'(V_BACK - 1));
            ACTIVE:  w_lineLast = (r_line == LINE_W'(IMG_HEIGHT - 1));
            VFRONT:  w_lineLast = (r_line == LINE_W'(V_FRONT - 1));
            default: w_lineLast = 1'b0;
        endcase
        if (r_state == IDLE) begin
            if (enable) w_nextState = VSYNC;
        end else if (!w_colLast) begin
            w_nextCol  = r_col + COL_W'(1);
            w_nextLine = r_line;
        end else if (!w_lineLast) begin
            w_nextLine = r_line + LINE_W'(1);
        end else begin
            unique case (r_state)
                VSYNC:   w_nextState = VBACK;
                VBACK:   w_nextState = ACTIVE;
                ACTIVE:  w_nextState = VFRONT;
                VFRONT:  w_nextState = enable ? VSYNC : IDLE;
                default: w_nextState = IDLE;
            endcase
        end
        w_enterVsync = (w_nextState == VSYNC) && (r_state != VSYNC);
    end

    always_comb begin
        w_vsync     = (w_nextState == VSYNC);
        w_href      = (w_nextState == ACTIVE) && (w_nextCol < COL_W'(ACTIVE_CLKS));
        w_data      = w_href ? packByte(w_rgb, w_nextCol[0]) : 8'h00;
        w_frameDone = (w_nextState == ACTIVE)
                    && (w_nextLine == LINE_W'(IMG_HEIGHT - 1))
                    && (w_nextCol == COL_W'(ACTIVE_CLKS - 1));
        w_busy      = (w_nextState != IDLE);
    end

    // Frame settings are captured only when a frame begins, so mid-frame changes wait.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_col        <= '0;
            r_line       <= '0;
            r_pattern    <= PAT_BARS;
            r_solid      <= 12'h000;
            r_frameCnt   <= 4'd0;
            r_vsync      <= 1'b0;
            r_href       <= 1'b0;
            r_data       <= 8'h00;
            r_frameStart <= 1'b0;
            r_frameDone  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_nextState;
            r_col        <= w_nextCol;
            r_line       <= w_nextLine;
            if (w_enterVsync) begin
                r_pattern  <= pattern_t'(pattern_sel);
                r_solid    <= solid_rgb;
                r_frameCnt <= r_frameCnt + 4'd1;
            end
            r_vsync      <= w_vsync;
            r_href       <= w_href;
            r_data       <= w_data;
            r_frameStart <= w_enterVsync;
            r_frameDone  <= w_frameDone;
            r_busy       <= w_busy;
        end
    end

    assign vsync       = r_vsync;
    assign href        = r_href;
    assign data        = r_data;
    assign frame_start = r_frameStart;
    assign frame_done  = r_frameDone;
    assign busy        = r_busy;

endmodule

// File: doc/ov7670_stream_gen.md
Name: ov7670_stream_gen

Overview:
- Synthesisable OV7670 camera emulator: the transmitting end of the camera pixel interface that ov7670_pixel_capture receives.
- Generates VSYNC/HREF/DATA[7:0] in OV7670 RGB444 two-byte format with programmable frame timing and built-in test patterns.
- Muxed in place of the physical camera pins, so the image_buffer, pattern_recognition and VGA path can be exercised on the bench or board without a sensor.
- Pattern set includes a zebra-stripe mode for crossing-detector bring-up.

Parameters:
- IMG_WIDTH, 320, active pixels per line (multiple of 8)
- IMG_HEIGHT, 240, active lines per frame
- H_BLANK, 144, clocks per line with HREF low after the active bytes
- VSYNC_LINES, 3, line periods with VSYNC high
- V_BACK, 17, blank line periods between VSYNC fall and the first active line
- V_FRONT, 10, blank line periods after the last active line
- STRIPE_H, 16, zebra band height in lines (power of two)

Ports:
- clk  in  1  byte clock; capture side samples on the same rising edge
- rst  in  1  synchronous, active-high reset
- enable  in  1  level; run frames while high
- pattern_sel  in  2  0 colour bars, 1 zebra, 2 solid, 3 ramp
- solid_rgb  in  12  RGB444 colour used by solid mode
- vsync  out  1  camera VSYNC
- href  out  1  camera HREF
- data  out  8  camera data byte
- frame_start  out  1  one-cycle pulse on the first VSYNC-high cycle
- frame_done  out  1  one-cycle pulse with the last active byte of a frame
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Timing constants:
  - LINE_CLKS = 2*IMG_WIDTH + H_BLANK
  - Frame length = (VSYNC_LINES + V_BACK + IMG_HEIGHT + V_FRONT) * LINE_CLKS clocks
- All outputs are registered. On reset, every output is 0, state is IDLE, and all counters are 0.
- States: IDLE, VSYNC, VBACK, ACTIVE, VFRONT. Each state uses a column counter (0..LINE_CLKS-1) and a line counter.
- IDLE: vsync, href, data and busy are 0. If enable is 1 at edge t, vsync and frame_start are 1 from cycle t+1.
- Frame-start latch: pattern_sel and solid_rgb are latched on entry to VSYNC and held for the whole frame. Changing them mid-frame has no effect until the next frame.
- VSYNC: vsync=1 for VSYNC_LINES*LINE_CLKS cycles, then go to VBACK.
- VBACK: vsync=0 for V_BACK*LINE_CLKS cycles, then go to ACTIVE.
- ACTIVE, per line y:
  - href=1 for columns 0..2*IMG_WIDTH-1, then href=0 for H_BLANK cycles.
  - Pixel x = column>>1.
  - Even column: data = {4'h0, R}. Odd column: data = {G, B}.
- Blanking and sync: data=0 whenever href=0.
- frame_done=1 in the cycle carrying byte (x=IMG_WIDTH-1, odd) of y=IMG_HEIGHT-1.
- VFRONT: V_FRONT*LINE_CLKS cycles, then:
  - enable=1 → go to VSYNC (back-to-back frames, frame counter +1);
  - enable=0 → go to IDLE.
- Enable deasserted mid-frame: the current frame always completes; no truncated frames.
- Patterns (RGB444):
  - Colour bars: 8 bars, each IMG_WIDTH/8 wide, in order FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
  - Zebra: y/STRIPE_H even → FFF, otherwise 000.
  - Solid: latched solid_rgb.
  - Ramp: R=x[3:0], G=y[3:0], B=frame_cnt[3:0], where frame_cnt is a 4-bit wrap counter incremented at each VSYNC entry and cleared by reset.
- Reset mid-frame: outputs are 0 on the cycle after reset is sampled high; the next frame starts cleanly from IDLE.
- Counter widths: $clog2 of each maximum. No counter may exceed its bound (column wraps at LINE_CLKS-1).

Decomposition:
- ov7670_pkg:
  - state enum (IDLE..VFRONT)
  - pattern enum (PAT_BARS, PAT_ZEBRA, PAT_SOLID, PAT_RAMP)
  - 8-entry colour-bar constant array
  - byte-packing helper function (rgb444, phase) → byte
- One sub-module, ov7670_pattern_gen: combinational mapping (x, y, frame_cnt, pattern, solid) → 12-bit RGB444.
- Timing FSM, counters and output registers stay in ov7670_stream_gen.

Test Plan (small parameters: IMG_WIDTH=16, IMG_HEIGHT=8, H_BLANK=4, VSYNC_LINES=1, V_BACK=1, V_FRONT=1 → LINE_CLKS=36, frame=396 clocks):
- Enable high, bars → vsync high exactly 36 cycles. Per frame: 8 href pulses, each 32 cycles. Line 0 bytes: 0F,FF,0F,FF,0F,F0,0F,F0,00,FF,… ending 00,00,00,00.
- Zebra with STRIPE_H=2 → lines 0-1 all bytes 0F/FF pairs; lines 2-3 all 00; alternating thereafter.
- Solid with solid_rgb=A5C → every pixel is 0A,5C. solid_rgb changed to 123 mid-ACTIVE → current frame stays 0A,5C; next frame is 01,23.
- Enable dropped at frame cycle 100 → frame runs to 396, frame_done pulses once, then busy=0 and vsync stays 0. No second frame_start.
- rst asserted in ACTIVE line 3 → next cycle vsync=href=data=busy=0. After release with enable=1, frame_start fires one cycle later.
- Loopback into ov7670_pixel_capture (ramp) → 128 we pulses per frame, last addr=127, pixel at (x=5, y=2) reads {5,2,frame_cnt}.
